// File: rtl/key_cmd_ctrl_if.sv
// Command handshake between the key controller and the parameter registers.
// The master holds cmd_key/cmd_repeat stable while cmd_valid is high and
// cmd_ready is low; a command transfers in any cycle where both are high.
interface key_cmd_ctrl_if #(
  parameter int KEY_W = 2
);
  logic             cmd_valid;
  logic [KEY_W-1:0] cmd_key;
  logic             cmd_repeat;
  logic             cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_key,
    output cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/key_cmd_ctrl.sv
// Key command controller.
// Turns debounced key levels into one command per press, arbitrated by fixed
// priority (lowest index wins), and issues auto-repeat commands while the
// winning key stays held. Commands sit in a single valid/ready slot; repeats
// that find the slot occupied are dropped rather than queued, so the consumer
// never sees a burst of stale repeats after backpressure.
module key_cmd_ctrl #(
  parameter int NUM_KEYS      = 4,
  parameter int KEY_W         = 2,
  parameter int CNT_W         = 26,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic                clk,
  input  logic                as_reset_n,
  input  logic [NUM_KEYS-1:0] key_level,
  key_cmd_ctrl_if.master      cmd_if
);

  // Timer terminal counts: a fire happens in the cycle the timer shows N-1,
  // so the resulting command is registered exactly N cycles after the
  // previous one.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [NUM_KEYS-1:0] armed_q, armed_d;
  logic [KEY_W-1:0]    owner_q, owner_d;
  logic                valid_q, valid_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                rep_q, rep_d;

  logic [NUM_KEYS-1:0] eligible;
  logic                slot_free;
  logic [KEY_W-1:0]    winner;
  logic                owner_held;
  logic                timer_last;

  // Fixed-priority pick: the lowest set bit of the request vector.
  function automatic logic [KEY_W-1:0] lowest_index(input logic [NUM_KEYS-1:0] req);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (req[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

  // Arbitration, slot status and timer terminal-count decode.
  always_comb begin
    eligible   = key_level & armed_q;
    slot_free  = !valid_q || cmd_if.cmd_ready;
    winner     = lowest_index(eligible);
    owner_held = key_level[owner_q];
    timer_last = (state_q == ST_HOLD) ? (timer_q == HOLD_LAST)
                                      : (timer_q == REP_LAST);
  end

  // Next-state logic for the FSM, timer, arming and the command slot.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    owner_d = owner_q;
    // A key re-arms in any cycle it is seen released.
    armed_d = armed_q | ~key_level;
    // Acceptance empties the slot; a load below overrides this.
    valid_d = valid_q && !cmd_if.cmd_ready;
    key_d   = key_q;
    rep_d   = rep_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        // Keys that lose, or that find the slot busy, keep their arm bit
        // and are picked up on a later cycle.
        if ((|eligible) && slot_free) begin
          valid_d          = 1'b1;
          key_d            = winner;
          rep_d            = 1'b0;
          armed_d[winner]  = 1'b0;
          owner_d          = winner;
          state_d          = ST_HOLD;
        end
      end

      ST_HOLD, ST_REPEAT: begin
        // Other keys are deliberately ignored here; only the owner matters.
        if (!owner_held) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_last) begin
          // The repeat grid keeps running even when the slot is busy.
          timer_d = '0;
          state_d = ST_REPEAT;
          if (slot_free) begin
            valid_d = 1'b1;
            key_d   = owner_q;
            rep_d   = 1'b1;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops any pending command.
  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      armed_q <= '1;
      owner_q <= '0;
      valid_q <= 1'b0;
      key_q   <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      armed_q <= armed_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      rep_q   <= rep_d;
    end
  end

  assign cmd_if.cmd_valid  = valid_q;
  assign cmd_if.cmd_key    = key_q;
  assign cmd_if.cmd_repeat = rep_q;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Testbench for key_cmd_ctrl with NUM_KEYS=4, HOLD_CYCLES=10, REPEAT_CYCLES=4.
// Scenario tables give persistent input changes per cycle and the cycle
// ranges in which a command is expected on the output; every other cycle
// must show cmd_valid low.
module tb_key_cmd_ctrl;

  logic       clk = 1'b0;
  logic       as_reset_n = 1'b1;
  logic [3:0] key_level = 4'b0000;

  key_cmd_ctrl_if #(.KEY_W(2)) cmd_if ();

  key_cmd_ctrl #(
    .NUM_KEYS      (4),
    .KEY_W         (2),
    .CNT_W         (8),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .as_reset_n (as_reset_n),
    .key_level  (key_level),
    .cmd_if     (cmd_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sc;
    int         cyc;
    logic [3:0] key;
    logic       rdy;
  } stim_t;

  typedef struct {
    int         sc;
    int         from;
    int         to;
    logic [1:0] ekey;
    logic       erep;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    sc_len[6];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int c,
                       input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req)
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, c, act, req);
    else
      pass_cnt++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    as_reset_n       = 1'b0;
    key_level        = 4'b0000;
    cmd_if.cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    as_reset_n = 1'b1;
  endtask

  task automatic run_sc(input int sc);
    logic       ev;
    logic [1:0] ek;
    logic       er;
    apply_reset();
    for (int c = 0; c < sc_len[sc]; c++) begin
      @(negedge clk);
      ev = 1'b0;
      ek = 2'd0;
      er = 1'b0;
      foreach (exp_q[j]) begin
        if (exp_q[j].sc == sc && c >= exp_q[j].from && c <= exp_q[j].to) begin
          ev = 1'b1;
          ek = exp_q[j].ekey;
          er = exp_q[j].erep;
        end
      end
      check($sformatf("s%0d_valid", sc), c, 32'(cmd_if.cmd_valid), 32'(ev));
      if (ev) begin
        check($sformatf("s%0d_key", sc), c, 32'(cmd_if.cmd_key), 32'(ek));
        check($sformatf("s%0d_repeat", sc), c, 32'(cmd_if.cmd_repeat), 32'(er));
      end
      foreach (stim_q[j]) begin
        if (stim_q[j].sc == sc && stim_q[j].cyc == c) begin
          key_level        = stim_q[j].key;
          cmd_if.cmd_ready = stim_q[j].rdy;
        end
      end
    end
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b1;

    // 0: single tap of key 2
    stim_q.push_back('{0, 5, 4'b0100, 1'b1});
    stim_q.push_back('{0, 8, 4'b0000, 1'b1});
    exp_q.push_back('{0, 6, 6, 2'd2, 1'b0});
    sc_len[0] = 30;
    // 1: key 1 held 30 cycles
    stim_q.push_back('{1, 5, 4'b0010, 1'b1});
    stim_q.push_back('{1, 35, 4'b0000, 1'b1});
    exp_q.push_back('{1, 6, 6, 2'd1, 1'b0});
    exp_q.push_back('{1, 16, 16, 2'd1, 1'b1});
    exp_q.push_back('{1, 20, 20, 2'd1, 1'b1});
    exp_q.push_back('{1, 24, 24, 2'd1, 1'b1});
    exp_q.push_back('{1, 28, 28, 2'd1, 1'b1});
    exp_q.push_back('{1, 32, 32, 2'd1, 1'b1});
    sc_len[1] = 45;
    // 2: keys 3 and 0 together, key 0 released at 8
    stim_q.push_back('{2, 5, 4'b1001, 1'b1});
    stim_q.push_back('{2, 8, 4'b1000, 1'b1});
    stim_q.push_back('{2, 16, 4'b0000, 1'b1});
    exp_q.push_back('{2, 6, 6, 2'd0, 1'b0});
    exp_q.push_back('{2, 10, 10, 2'd3, 1'b0});
    sc_len[2] = 30;
    // 3: rearm needs a low cycle; held key only repeats
    stim_q.push_back('{3, 5, 4'b0100, 1'b1});
    stim_q.push_back('{3, 18, 4'b0000, 1'b1});
    stim_q.push_back('{3, 19, 4'b0100, 1'b1});
    stim_q.push_back('{3, 22, 4'b0000, 1'b1});
    exp_q.push_back('{3, 6, 6, 2'd2, 1'b0});
    exp_q.push_back('{3, 16, 16, 2'd2, 1'b1});
    exp_q.push_back('{3, 20, 20, 2'd2, 1'b0});
    sc_len[3] = 30;
    // 4: backpressure for 20 cycles while key 0 held
    stim_q.push_back('{4, 5, 4'b0001, 1'b0});
    stim_q.push_back('{4, 25, 4'b0001, 1'b1});
    stim_q.push_back('{4, 34, 4'b0000, 1'b1});
    exp_q.push_back('{4, 6, 25, 2'd0, 1'b0});
    exp_q.push_back('{4, 28, 28, 2'd0, 1'b1});
    exp_q.push_back('{4, 32, 32, 2'd0, 1'b1});
    sc_len[4] = 45;
    // 5: waiting key loads in the same edge the pending command is taken
    stim_q.push_back('{5, 5, 4'b1001, 1'b0});
    stim_q.push_back('{5, 8, 4'b1000, 1'b0});
    stim_q.push_back('{5, 10, 4'b1000, 1'b1});
    stim_q.push_back('{5, 15, 4'b0000, 1'b1});
    exp_q.push_back('{5, 6, 10, 2'd0, 1'b0});
    exp_q.push_back('{5, 11, 11, 2'd3, 1'b0});
    sc_len[5] = 25;

    // Reset state
    @(negedge clk);
    as_reset_n = 1'b0;
    #1;
    check("reset_valid", 0, 32'(cmd_if.cmd_valid), 32'd0);
    check("reset_key", 0, 32'(cmd_if.cmd_key), 32'd0);
    check("reset_repeat", 0, 32'(cmd_if.cmd_repeat), 32'd0);

    for (int s = 0; s < 6; s++) run_sc(s);

    // Reset asserted mid-repeat with a pending command
    apply_reset();
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 5) key_level = 4'b0010;
      if (c == 16) begin
        check("pre_rst_valid", c, 32'(cmd_if.cmd_valid), 32'd1);
        check("pre_rst_repeat", c, 32'(cmd_if.cmd_repeat), 32'd1);
        cmd_if.cmd_ready = 1'b0;
      end
      if (c == 17) check("pre_rst_held", c, 32'(cmd_if.cmd_valid), 32'd1);
    end
    #2;
    as_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 17, 32'(cmd_if.cmd_valid), 32'd0);
    check("mid_rst_key", 17, 32'(cmd_if.cmd_key), 32'd0);
    check("mid_rst_repeat", 17, 32'(cmd_if.cmd_repeat), 32'd0);
    repeat (2) @(negedge clk);
    as_reset_n       = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 0, 32'(cmd_if.cmd_valid), 32'd1);
    check("post_rst_key", 0, 32'(cmd_if.cmd_key), 32'd1);
    check("post_rst_repeat", 0, 32'(cmd_if.cmd_repeat), 32'd0);
    @(negedge clk);
    check("post_rst_single", 1, 32'(cmd_if.cmd_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
